button_cond: RTL and testbench

BUTTON_COND -- requirements
Module: button_cond

---
 rtl/button_cond.sv | 105 ++++++++++
 tb/tb_button_cond.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_cond.sv
// button_cond: synchronized, debounced push-button with press pulse and step strobe; define BUTTON_COND_HOLD_REPEAT_EN for auto-repeat while held
module button_cond #(
  parameter int DEB_CYCLES    = 20000,
  parameter int DIV_CYCLES    = 50000000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic button,
  output logic press,
  output logic step
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(DIV_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  state_t r_state, w_state_nxt;
  logic r_sync1, r_sync2;
  logic [DW-1:0] r_deb, w_deb_nxt;
  logic r_press, w_press_nxt, w_accept;
  logic [SW-1:0] r_div;
  logic r_run;
  // two-flop synchronizer; only r_sync2 is used downstream
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_sync1, r_sync2} <= 2'b00;
    else {r_sync1, r_sync2} <= {btn_raw, r_sync1};
  // debounce state, stability counter and registered press pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_deb   <= '0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_deb   <= w_deb_nxt;
      r_press <= w_press_nxt;
    end
  // next-state logic: a level change is accepted after DEB_CYCLES+1 agreeing samples
  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb;
    w_accept    = 1'b0;
    case (r_state)
      IDLE:
        if (r_sync2) begin
          w_state_nxt = PRESS_WAIT;
          w_deb_nxt   = DW'(1);
        end
      PRESS_WAIT:
        if (!r_sync2) begin
          w_state_nxt = IDLE;
          w_deb_nxt   = '0;
        end else if (r_deb == DW'(DEB_CYCLES)) begin
          w_state_nxt = HELD;
          w_deb_nxt   = '0;
          w_accept    = 1'b1;
        end else w_deb_nxt = r_deb + DW'(1);
      HELD:
        if (!r_sync2) begin
          w_state_nxt = RELEASE_WAIT;
          w_deb_nxt   = DW'(1);
        end
      RELEASE_WAIT:
        if (r_sync2) begin
          w_state_nxt = HELD;
          w_deb_nxt   = '0;
        end else if (r_deb == DW'(DEB_CYCLES)) begin
          w_state_nxt = IDLE;
          w_deb_nxt   = '0;
        end else w_deb_nxt = r_deb + DW'(1);
      default: begin
        w_state_nxt = IDLE;
        w_deb_nxt   = '0;
      end
    endcase
  end
`ifdef BUTTON_COND_HOLD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] r_rep;
  logic w_hold, w_rep_hit;
  assign w_hold    = (r_state == HELD) && r_sync2;
  assign w_rep_hit = w_hold && (r_rep == RW'(REPEAT_CYCLES - 1));
  // repeat counter runs only while staying in HELD, otherwise held at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) r_rep <= '0;
    else r_rep <= (w_hold && !w_rep_hit) ? r_rep + RW'(1) : '0;
  assign w_press_nxt = w_accept | w_rep_hit;
`else
  logic w_unused;
  assign w_unused    = (REPEAT_CYCLES > 0);
  assign w_press_nxt = w_accept;
`endif
  // free-running step divider; r_run keeps the count at 0 on the first edge so the first step follows edge DIV_CYCLES
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_div <= '0;
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_run) r_div <= (r_div == SW'(DIV_CYCLES - 1)) ? '0 : r_div + SW'(1);
    end
  assign button = (r_state == HELD) || (r_state == RELEASE_WAIT);
  assign press  = r_press;
  assign step   = r_run && (r_div == SW'(DIV_CYCLES - 1));
endmodule

// File: tb/tb_button_cond.sv
// tb_button_cond: randomized and directed checks of button_cond against a run-length reference model
module tb_button_cond;
  localparam int DEB = 4;
  localparam int DIV = 5;
  localparam int REP = 8;
`ifdef BUTTON_COND_HOLD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic button, press, step;
  int errors = 0;
  int checks = 0;
  logic smp0, smp1, m_level, m_press, m_step;
  int run, hold, n;

  button_cond #(.DEB_CYCLES(DEB), .DIV_CYCLES(DIV), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .button(button), .press(press), .step(step)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    smp0 = 0; smp1 = 0; m_level = 0; m_press = 0; m_step = 0;
    run = 0; hold = 0; n = 0;
  endtask

  // drive btn_raw, advance one edge, update model: a level is accepted when DEB+1
  // consecutive synchronized samples (raw delayed two edges) disagree with it
  task automatic tick(input logic raw);
    logic s;
    btn_raw = raw;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      s = smp1; smp1 = smp0; smp0 = btn_raw;
      n++;
      m_step = (n % DIV == 0);
      m_press = 0;
      if (s != m_level) begin
        run++; hold = 0;
        if (run == DEB + 1) begin m_level = s; run = 0; m_press = s; end
      end else begin
        if (m_level && run == 0) begin
          hold++;
          if (REP_EN && hold % REP == 0) m_press = 1;
        end else hold = 0;
        run = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      tick(i[0]);
      checks++;
      if ({button, press, step} !== 3'b000) begin
        errors++; $display("FAIL reset c%0d: got b/p/s=%b%b%b want 000", i, button, press, step);
      end
    end
    rst = 0;
  endtask

  task automatic test_step();
    int cnt = 0, first = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(0);
      checks++;
      if ({button, press, step} !== {m_level, m_press, m_step}) begin
        errors++; $display("FAIL step c%0d: got b/p/s=%b%b%b want %b%b%b", i, button, press, step, m_level, m_press, m_step);
      end
      if (step) begin cnt++; if (first == 0) first = i; end
    end
    checks++;
    if (cnt !== 8) begin errors++; $display("FAIL step_count: got %0d want 8", cnt); end
    checks++;
    if (first !== DIV) begin errors++; $display("FAIL step_first: got %0d want %0d", first, DIV); end
  endtask

  task automatic test_clean();
    int t_press = 0, t_fall = 0, rel_press = 0;
    for (int i = 1; i <= 28; i++) begin
      tick(1);
      checks++;
      if ({button, press, step} !== {m_level, m_press, m_step}) begin
        errors++; $display("FAIL clean c%0d: got b/p/s=%b%b%b want %b%b%b", i, button, press, step, m_level, m_press, m_step);
      end
      if (press && t_press == 0) t_press = i;
    end
    checks++;
    if (t_press !== DEB + 3) begin errors++; $display("FAIL clean_latency: got %0d want %0d", t_press, DEB + 3); end
    for (int i = 1; i <= 12; i++) begin
      tick(0);
      checks++;
      if ({button, press, step} !== {m_level, m_press, m_step}) begin
        errors++; $display("FAIL release c%0d: got b/p/s=%b%b%b want %b%b%b", i, button, press, step, m_level, m_press, m_step);
      end
      if (!button && t_fall == 0) t_fall = i;
      if (press) rel_press++;
    end
    checks++;
    if (t_fall !== DEB + 3) begin errors++; $display("FAIL release_latency: got %0d want %0d", t_fall, DEB + 3); end
    checks++;
    if (rel_press !== 0) begin errors++; $display("FAIL release_press: got %0d want 0", rel_press); end
  endtask

  task automatic test_bounce();
    logic [7:0] pat = 8'b00110011;
    int b_press = 0, t_press = 0;
    for (int i = 0; i < 8; i++) begin
      tick(pat[i]);
      checks++;
      if ({button, press, step} !== {m_level, m_press, m_step}) begin
        errors++; $display("FAIL bounce c%0d: got b/p/s=%b%b%b want %b%b%b", i, button, press, step, m_level, m_press, m_step);
      end
      if (press) b_press++;
    end
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      checks++;
      if ({button, press, step} !== {m_level, m_press, m_step}) begin
        errors++; $display("FAIL settle c%0d: got b/p/s=%b%b%b want %b%b%b", i, button, press, step, m_level, m_press, m_step);
      end
      if (press && t_press == 0) t_press = i;
      if (press && i < DEB + 3) b_press++;
    end
    checks++;
    if (b_press !== 0) begin errors++; $display("FAIL bounce_press: got %0d want 0", b_press); end
    checks++;
    if (t_press !== DEB + 3) begin errors++; $display("FAIL bounce_latency: got %0d want %0d", t_press, DEB + 3); end
    for (int i = 0; i < 10; i++) tick(0);
  endtask

  task automatic test_reset_mid();
    int t_press = 0, cnt = 0;
    for (int i = 0; i < 10; i++) tick(1);
    checks++;
    if (button !== 1'b1) begin errors++; $display("FAIL mid_held: got button=%b want 1", button); end
    #2 rst = 1;
    #1;
    model_reset();
    checks++;
    if ({button, press, step} !== 3'b000) begin
      errors++; $display("FAIL mid_async: got b/p/s=%b%b%b want 000", button, press, step);
    end
    #1;
    for (int i = 0; i < 2; i++) tick(1);
    rst = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      checks++;
      if ({button, press, step} !== {m_level, m_press, m_step}) begin
        errors++; $display("FAIL mid_redo c%0d: got b/p/s=%b%b%b want %b%b%b", i, button, press, step, m_level, m_press, m_step);
      end
      if (press) begin cnt++; if (t_press == 0) t_press = i; end
    end
    checks++;
    if (t_press !== DEB + 3) begin errors++; $display("FAIL mid_latency: got %0d want %0d", t_press, DEB + 3); end
    checks++;
    if (cnt !== 1) begin errors++; $display("FAIL mid_count: got %0d want 1", cnt); end
    for (int i = 0; i < 10; i++) tick(0);
  endtask

  task automatic test_repeat();
    int cnt = 0;
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1);
      if (press) begin got = 1; cnt++; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL repeat_accept: got no press within 20 cycles want 1"); end
    for (int i = 1; i <= 28; i++) begin
      tick(1);
      checks++;
      if ({button, press, step} !== {m_level, m_press, m_step}) begin
        errors++; $display("FAIL repeat c%0d: got b/p/s=%b%b%b want %b%b%b", i, button, press, step, m_level, m_press, m_step);
      end
      if (press) cnt++;
    end
    for (int i = 0; i < 10; i++) begin tick(0); if (press) cnt++; end
    checks++;
    if (cnt !== (REP_EN ? 4 : 1)) begin errors++; $display("FAIL repeat_count: got %0d want %0d", cnt, REP_EN ? 4 : 1); end
  endtask

  task automatic test_random();
    int left = 0;
    logic lvl = 0;
    for (int i = 0; i < 800; i++) begin
      if (left == 0) begin
        lvl = 1'($urandom_range(0, 1));
        left = $urandom_range(1, 2 * DEB + 4);
      end
      left--;
      tick(lvl);
      checks++;
      if ({button, press, step} !== {m_level, m_press, m_step}) begin
        errors++; $display("FAIL random c%0d: got b/p/s=%b%b%b want %b%b%b", i, button, press, step, m_level, m_press, m_step);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_step();
    test_clean();
    test_bounce();
    test_reset_mid();
    test_repeat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
